// File: rtl/ysyx_041514_ex_mdu_pkg.sv
// Shared definitions for the EX-stage RV64M multiply/divide unit:
// MDU op encodings (next to the existing ALUOP/MEMOP encodings), FSM states, op decode and result fix-up.
// No ports; imported by the interface, the top and the sub-modules.
package ysyx_041514_ex_mdu_pkg;

  localparam int XLEN = 64;

  localparam int ysyx_041514_MDUOP_LEN = 4;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_MUL    = 4'd0;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_MULH   = 4'd1;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_MULHSU = 4'd2;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_MULHU  = 4'd3;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_DIV    = 4'd4;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_DIVU   = 4'd5;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_REM    = 4'd6;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_REMU   = 4'd7;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_MULW   = 4'd8;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_DIVW   = 4'd9;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_DIVUW  = 4'd10;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_REMW   = 4'd11;
  localparam logic [ysyx_041514_MDUOP_LEN-1:0] ysyx_041514_MDUOP_REMUW  = 4'd12;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

  typedef struct packed {
    logic is_mul;    // shift-add path (all MUL* ops)
    logic is_rem;    // result is the remainder
    logic is_w;      // 32-bit operand/result op
    logic w_signed;  // W operands sign-extended (else zero-extended)
    logic signed_a;
    logic signed_b;
    logic rsvd;
  } mdu_dec_t;

  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [31:0] v);
    return {32'b0, v};
  endfunction

  function automatic mdu_dec_t mdu_decode(input logic [ysyx_041514_MDUOP_LEN-1:0] op);
    mdu_dec_t d;
    d = '0;
    case (op)
      ysyx_041514_MDUOP_MUL:    d.is_mul = 1'b1;
      ysyx_041514_MDUOP_MULH:   begin d.is_mul = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ysyx_041514_MDUOP_MULHSU: begin d.is_mul = 1'b1; d.signed_a = 1'b1; end
      ysyx_041514_MDUOP_MULHU:  d.is_mul = 1'b1;
      ysyx_041514_MDUOP_DIV:    begin d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ysyx_041514_MDUOP_DIVU:   ;
      ysyx_041514_MDUOP_REM:    begin d.is_rem = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ysyx_041514_MDUOP_REMU:   d.is_rem = 1'b1;
      ysyx_041514_MDUOP_MULW:   begin
        d.is_mul = 1'b1; d.is_w = 1'b1; d.w_signed = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1;
      end
      ysyx_041514_MDUOP_DIVW:   begin d.is_w = 1'b1; d.w_signed = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1; end
      ysyx_041514_MDUOP_DIVUW:  d.is_w = 1'b1;
      ysyx_041514_MDUOP_REMW:   begin
        d.is_rem = 1'b1; d.is_w = 1'b1; d.w_signed = 1'b1; d.signed_a = 1'b1; d.signed_b = 1'b1;
      end
      ysyx_041514_MDUOP_REMUW:  begin d.is_rem = 1'b1; d.is_w = 1'b1; end
      default:                  d.rsvd = 1'b1;
    endcase
    return d;
  endfunction

  // acc holds the unsigned product, or {remainder, quotient} for divides.
  // neg is the sign of whichever half the op returns.
  function automatic logic [XLEN-1:0] mdu_fixup(input logic [ysyx_041514_MDUOP_LEN-1:0] op,
                                                input logic neg,
                                                input logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   res;
    prod = neg ? -acc : acc;
    quo  = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem  = neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    case (op)
      ysyx_041514_MDUOP_MUL:                           res = prod[XLEN-1:0];
      ysyx_041514_MDUOP_MULH, ysyx_041514_MDUOP_MULHSU,
      ysyx_041514_MDUOP_MULHU:                         res = prod[2*XLEN-1:XLEN];
      ysyx_041514_MDUOP_MULW:                          res = sext32(prod[31:0]);
      ysyx_041514_MDUOP_DIV, ysyx_041514_MDUOP_DIVU:   res = quo;
      ysyx_041514_MDUOP_REM, ysyx_041514_MDUOP_REMU:   res = rem;
      ysyx_041514_MDUOP_DIVW, ysyx_041514_MDUOP_DIVUW: res = sext32(quo[31:0]);
      ysyx_041514_MDUOP_REMW, ysyx_041514_MDUOP_REMUW: res = sext32(rem[31:0]);
      default:                                         res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ysyx_041514_ex_mdu_if.sv
// ID/EX-to-MDU bundle: flush, start, op and operands in; stall request, done pulse and result out.
// master = pipeline side (drives operands), slave = MDU.
interface ysyx_041514_ex_mdu_if;
  logic                                                             flush_i;
  logic                                                             start_i;
  logic [ysyx_041514_ex_mdu_pkg::ysyx_041514_MDUOP_LEN-1:0]         op_i;
  logic [ysyx_041514_ex_mdu_pkg::XLEN-1:0]                          rs1_data_i;
  logic [ysyx_041514_ex_mdu_pkg::XLEN-1:0]                          rs2_data_i;
  logic                                                             busy_o;
  logic                                                             done_o;
  logic [ysyx_041514_ex_mdu_pkg::XLEN-1:0]                          result_o;

  modport master (
    output flush_i, start_i, op_i, rs1_data_i, rs2_data_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  flush_i, start_i, op_i, rs1_data_i, rs2_data_i,
    output busy_o, done_o, result_o
  );
endinterface

// File: rtl/ysyx_041514_mdu_div_core.sv
// One restoring-division step (combinational): shift {rem, quo} left, trial-subtract divisor.
// Ports: rem_i/quo_i/divisor_i -> rem_o/quo_o. quo_i carries the remaining dividend bits in its MSBs.
module ysyx_041514_mdu_div_core #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;
  logic          fits;

  // rem_i < divisor, so the shifted partial remainder needs one extra bit;
  // a borrow shows up in the top bit of the trial difference.
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {1'b0, divisor_i};
  assign fits    = ~trial[XLEN];
  assign rem_o   = fits ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], fits};
endmodule

// File: rtl/ysyx_041514_regTemplate.sv
// Generic register with synchronous active-high reset and write enable.
// Ports: clk, rst, wen_i, din_i -> dout_o.
module ysyx_041514_regTemplate #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_o <= RESET_VAL;
    end else if (wen_i) begin
      dout_o <= din_i;
    end
  end
endmodule

// File: rtl/ysyx_041514_ex_mdu.sv
// Iterative RV64M multiply/divide unit in EX: one bit per cycle, stalls ID/EX via busy_o, one-cycle done_o.
// Ports: clk, rst (sync, active-high), mdu (slave modport: flush/start/op/rs1/rs2 in, busy/done/result out).
// Optional YSYX_041514_FAST_MUL_EN: multiplies finish in one cycle with a single '*'.
module ysyx_041514_ex_mdu
  import ysyx_041514_ex_mdu_pkg::*;
(
  input logic                  clk,
  input logic                  rst,
  ysyx_041514_ex_mdu_if.slave  mdu
);
  localparam int CNT_W = $clog2(XLEN);

  mdu_state_e                       state_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [ysyx_041514_MDUOP_LEN-1:0] op_q;
  logic                             neg_q;
  logic [XLEN-1:0]                  opb_q;
  logic [2*XLEN-1:0]                acc_q;   // mul: {partial sum, multiplier}; div: {rem, quo}
  logic                             done_q;

  mdu_dec_t        dec;
  logic [XLEN-1:0] a_ext, b_ext, mag_a, mag_b;
  logic            sign_a, sign_b, neg_in;
  logic            div_zero, fast_mul, direct, accept;

  // ---------------- operand preparation (IDLE) ----------------
  assign dec = mdu_decode(mdu.op_i);

  always_comb begin
    a_ext = mdu.rs1_data_i;
    b_ext = mdu.rs2_data_i;
    if (dec.is_w) begin
      a_ext = dec.w_signed ? sext32(mdu.rs1_data_i[31:0]) : zext32(mdu.rs1_data_i[31:0]);
      b_ext = dec.w_signed ? sext32(mdu.rs2_data_i[31:0]) : zext32(mdu.rs2_data_i[31:0]);
    end
  end

  assign sign_a   = dec.signed_a & a_ext[XLEN-1];
  assign sign_b   = dec.signed_b & b_ext[XLEN-1];
  // Magnitude of the most negative value is 2^(XLEN-1), which is exact as unsigned,
  // so min / -1 falls out of the magnitude path without a special case.
  assign mag_a    = sign_a ? -a_ext : a_ext;
  assign mag_b    = sign_b ? -b_ext : b_ext;
  assign neg_in   = dec.is_rem ? sign_a : (sign_a ^ sign_b);
  assign div_zero = ~dec.is_mul & ~dec.rsvd & (b_ext == '0);

`ifdef YSYX_041514_FAST_MUL_EN
  assign fast_mul = dec.is_mul;
`else
  assign fast_mul = 1'b0;
`endif

  assign direct = div_zero | dec.rsvd | fast_mul;
  assign accept = (state_q == MDU_IDLE) & mdu.start_i & ~mdu.flush_i;

  // Result of ops that skip CALC. Divide by zero reuses the divide fix-up with
  // {rem = extended dividend, quo = all ones} and no sign correction.
  logic [2*XLEN-1:0] idle_acc;
  logic              idle_neg;

  always_comb begin
    idle_acc = '0;
    if (div_zero) begin
      idle_acc = {a_ext, {XLEN{1'b1}}};
    end
`ifdef YSYX_041514_FAST_MUL_EN
    else if (dec.is_mul) begin
      idle_acc = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    end
`endif
  end

  assign idle_neg = div_zero ? 1'b0 : neg_in;

  // ---------------- per-cycle step (CALC) ----------------
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN-1:0]   div_rem, div_quo;
  logic [2*XLEN-1:0] step_acc;
  logic              op_is_mul;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  ysyx_041514_mdu_div_core #(.XLEN(XLEN)) u_div_core (
    .rem_i     (acc_q[2*XLEN-1:XLEN]),
    .quo_i     (acc_q[XLEN-1:0]),
    .divisor_i (opb_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );

  assign op_is_mul = mdu_decode(op_q).is_mul;
  assign step_acc  = op_is_mul ? mul_next : {div_rem, div_quo};

  // ---------------- result register ----------------
  logic [XLEN-1:0] result_d;
  logic            result_wen;

  always_comb begin
    result_wen = 1'b0;
    result_d   = mdu_fixup(op_q, neg_q, step_acc);
    if (accept & direct) begin
      result_wen = 1'b1;
      result_d   = mdu_fixup(mdu.op_i, idle_neg, idle_acc);
    end else if ((state_q == MDU_CALC) & ~mdu.flush_i & (cnt_q == '0)) begin
      result_wen = 1'b1;
    end
  end

  ysyx_041514_regTemplate #(.WIDTH(XLEN), .RESET_VAL('0)) u_result_reg (
    .clk    (clk),
    .rst    (rst),
    .wen_i  (result_wen),
    .din_i  (result_d),
    .dout_o (mdu.result_o)
  );

  // ---------------- control FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mdu.flush_i) begin
        state_q <= MDU_IDLE;
      end else begin
        case (state_q)
          MDU_IDLE: begin
            if (mdu.start_i) begin
              op_q  <= mdu.op_i;
              neg_q <= neg_in;
              opb_q <= mag_b;
              acc_q <= {{XLEN{1'b0}}, mag_a};
              if (direct) begin
                state_q <= MDU_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= MDU_CALC;
                cnt_q   <= CNT_W'(XLEN - 1);
              end
            end
          end
          MDU_CALC: begin
            acc_q <= step_acc;
            if (cnt_q == '0) begin
              state_q <= MDU_DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          MDU_DONE: begin
            // start_i still shows the completing instruction here; ignore it.
            state_q <= MDU_IDLE;
          end
          default: state_q <= MDU_IDLE;
        endcase
      end
    end
  end

  assign mdu.busy_o = ~mdu.flush_i & (((state_q == MDU_IDLE) & mdu.start_i) | (state_q == MDU_CALC));
  assign mdu.done_o = done_q;

endmodule

// File: doc/ysyx_041514_ex_mdu.md
# ysyx_041514_ex_mdu

Iterative RV64M multiply/divide unit in the EX stage, fed directly by the ID/EX pipeline register outputs (operands and op code). It accepts one M-extension operation while idle, raises a stall request so ID/EX and upstream registers hold, and iterates one bit per cycle. It presents the result for exactly one cycle so the EX/MEM register can capture it.

## Interface
- XLEN, 64, operand and result width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  flush of the EX slot (EX bit of the flush control bus).
- start_i  in  1  valid M-extension op present at ID/EX outputs.
- op_i  in  4  MDU op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU, 8 MULW, 9 DIVW, 10 DIVUW, 11 REMW, 12 REMUW; 13–15 reserved.
- rs1_data_i  in  XLEN  operand A.
- rs2_data_i  in  XLEN  operand B.
- busy_o  out  1  stall request into the EX bit of the stall control bus (combinational).
- done_o  out  1  one-cycle pulse; result_o valid.
- result_o  out  XLEN  result; holds its value until the next done_o.

## Operation
- States: IDLE, CALC, DONE. Reset: IDLE, counter 0, result_o 0, done_o 0, busy_o 0.
- IDLE:
  - On start_i & !flush_i: latch op, operand magnitudes, and result-sign flags.
  - Divide by zero or reserved op → DONE. Otherwise → CALC with counter = XLEN-1.
- CALC:
  - Multiply: one shift-add step per cycle into a 2*XLEN accumulator.
  - Divide: one restoring step per cycle (remainder/quotient shift, trial subtract).
  - Counter 0 → DONE.
- DONE: done_o=1; result_o loaded with the final result on entry; → IDLE. start_i is ignored in DONE, because it still shows the completing instruction.
- Operand rules:
  - Signed operands: DIV, REM, MULH (both), MULHSU (rs1 only).
  - W ops: operands sign-extended from bit 31 (MULW, DIVW, REMW) or zero-extended (DIVUW, REMUW); result sign-extended from bit 31.
  - Signed results are computed on magnitudes, then negated: quotient sign = signA^signB; remainder sign = signA; product sign = signA^signB.
- Results: MUL/MULW take the low half of the product; MULH* take the high XLEN bits.
- Divide by zero: quotient all ones; remainder = dividend (after W extension, then sign-extended).
- Signed overflow (min / -1): quotient = min, remainder 0. The magnitude path yields this naturally; no special case.
- Reserved op: result 0.
- flush_i in any state → IDLE next cycle, no done_o, result_o unchanged. flush_i wins over start_i in the same cycle.

## Timing
- busy_o = (IDLE & start_i & !flush_i) | (CALC & !flush_i). busy_o is low in DONE, so ID/EX advances at the end of DONE.
- Normal op accepted in cycle 0:
  - busy_o high in cycles 0..XLEN (XLEN+1 cycles).
  - done_o in cycle XLEN+1.
- Divide-by-zero or reserved op: busy_o high in cycle 0 only; done_o in cycle 1.
- Next start is accepted no earlier than the cycle after DONE.
- rst mid-operation: IDLE next cycle, all outputs return to reset values.

## Configuration
- YSYX_041514_FAST_MUL_EN defined:
  - All multiply ops compute the full product with a single-cycle `*` (unsigned magnitudes) and go IDLE→DONE.
  - busy_o is high 1 cycle; done_o arrives in cycle 1.
  - Divide is unchanged.
- Undefined: multiply is iterative, XLEN cycles as above.

## Structure
- Shared config header gains ysyx_041514_MDUOP_LEN (4) and ysyx_041514_MDUOP_* encodings next to the existing ALUOP/MEMOP definitions.
- The result register is a ysyx_041514_regTemplate instance: rst → 0, wen = entering DONE.
- One sub-module: ysyx_041514_mdu_div_core, the per-cycle restoring-division step (remainder/quotient in, next remainder/quotient out, combinational). The FSM, multiplier and sign fix-up stay in the top module.

## Test plan
- MUL 7 × -3 (0xFFFF_FFFF_FFFF_FFFD) → result_o 0xFFFF_FFFF_FFFF_FFEB; busy_o high 65 cycles; done_o in cycle 65.
- MULH 0x8000_0000_0000_0000 × 2 → 0xFFFF_FFFF_FFFF_FFFF. MULHU on the same operands → 1.
- DIVU 5 / 0 → 0xFFFF_FFFF_FFFF_FFFF and REM 5 / 0 → 5; each with busy_o 1 cycle and done_o in cycle 1.
- DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000. REM on the same operands → 0.
- DIVW 0x0000_0000_8000_0000 / -1 → 0xFFFF_FFFF_8000_0000. REMUW 7 / 2 → 1.
- DIV 100 / 7 with flush_i in cycle 10 → busy_o low in cycle 10, no done_o, result_o unchanged.
  - A new DIVU 100 / 7 started in cycle 11 → 14, with done_o in cycle 76.
  - start_i held high through DONE → no second operation.
